// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: operation encoding and excitation helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package jk_pkg;

   // {J,K} encoding of the four JK flip-flop operations
   typedef enum logic [1:0] {
      HOLD = 2'b00,
      CLR  = 2'b01,
      SET  = 2'b10,
      TOG  = 2'b11
   } jk_op_t;

   // Excitation for present bit q and desired next bit n. A changing bit
   // gets SET or CLR, never TOG, so the result never depends on toggling.
   function automatic jk_op_t jk_excite(input logic q, input logic n);
      return jk_op_t'({~q & n, q & ~n});
   endfunction

endpackage

// File: rtl/jk_ff.sv
// Rising-edge JK flip-flop with asynchronous active-low clear.
// Latency: Q updates one CLK edge after J/K; clears immediately on RST_N low.
// Backpressure: none; J=K=0 holds the stored bit.
module jk_ff
   import jk_pkg::*;
(
   input  logic CLK,
   input  logic RST_N,
   input  logic J,
   input  logic K,
   output logic Q,
   output logic not_Q
);

   // Full JK table on the rising edge, asynchronous clear to 0
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Q <= 1'b0;
      end else begin
         case (jk_op_t'({J, K}))
            HOLD:    Q <= Q;
            CLR:     Q <= 1'b0;
            SET:     Q <= 1'b1;
            TOG:     Q <= ~Q;
            default: Q <= Q;
         endcase
      end
   end

   // Complement output follows the stored bit, so it reads 1 during reset
   assign not_Q = ~Q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from one JK flip-flop per bit.
// Latency: Q/not_Q one CLK edge after LOAD/EN; TC is combinational (zero latency).
// Backpressure: none; EN=0 with LOAD=0 holds the count (all bits get JK=00).
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,   // at least 2
   parameter int MODULUS = 10   // 2 .. 2**WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             UP,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] not_Q,
   output logic             TC
);

   // Highest legal count; also the clamp value for oversized loads.
   // Wrap is found by comparing against this or zero, never by carry-out,
   // so non-power-of-two moduli wrap exactly.
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] next_q;
   logic [WIDTH-1:0] j_bits;
   logic [WIDTH-1:0] k_bits;

   // Desired next count: load (with clamp) beats count, count beats hold
   always_comb begin
      next_q = Q;
      if (LOAD) begin
         next_q = (D > MAX_CNT) ? MAX_CNT : D;
      end else if (EN) begin
         if (Q > MAX_CNT) begin
            next_q = '0;                         // recover from an illegal state
         end else if (UP) begin
            next_q = (Q == MAX_CNT) ? '0 : Q + WIDTH'(1);
         end else begin
            next_q = (Q == '0) ? MAX_CNT : Q - WIDTH'(1);
         end
      end
   end

   // One flip-flop per bit, excited from present vs. desired value
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign {j_bits[i], k_bits[i]} = jk_excite(Q[i], next_q[i]);

      jk_ff u_ff (
         .CLK   (CLK),
         .RST_N (RST_N),
         .J     (j_bits[i]),
         .K     (k_bits[i]),
         .Q     (Q[i]),
         .not_Q (not_Q[i])
      );
   end

   // Terminal count predicts the wrap on the coming edge, for cascading
   assign TC = EN & ~LOAD & ((UP & (Q == MAX_CNT)) | (~UP & (Q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] d;
   logic [3:0] q;
   logic [3:0] not_q;
   logic       tc;

   // cascade pair, MODULUS=16
   logic       c_rst_n;
   logic [3:0] lo_q, lo_nq, hi_q, hi_nq;
   logic       lo_tc, hi_tc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .CLK(clk), .RST_N(rst_n), .EN(en), .UP(up), .LOAD(load),
      .D(d), .Q(q), .not_Q(not_q), .TC(tc)
   );

   jk_mod_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
      .CLK(clk), .RST_N(c_rst_n), .EN(1'b1), .UP(1'b1), .LOAD(1'b0),
      .D(4'd0), .Q(lo_q), .not_Q(lo_nq), .TC(lo_tc)
   );

   jk_mod_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
      .CLK(clk), .RST_N(c_rst_n), .EN(lo_tc), .UP(1'b1), .LOAD(1'b0),
      .D(4'd0), .Q(hi_q), .not_Q(hi_nq), .TC(hi_tc)
   );

   // advance one rising edge, leaving time for outputs to settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;
      #3;
      total++;
      if (q !== 4'd0) begin bad++; $display("FAIL reset_q: got %0d want 0", q); end
      total++;
      if (not_q !== 4'b1111) begin bad++; $display("FAIL reset_nq: got %b want 1111", not_q); end
      total++;
      if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc_idle: got %b want 0", tc); end
      en = 1'b1; up = 1'b0; #1;
      total++;
      if (tc !== 1'b1) begin bad++; $display("FAIL reset_tc_down: got %b want 1", tc); end
      step();
      total++;
      if (q !== 4'd0) begin bad++; $display("FAIL reset_edge_hold: got %0d want 0", q); end
   endtask

   task automatic test_reset_mid_count();
      en = 1'b0; up = 1'b1;
      rst_n = 1'b1;
      step();
      en = 1'b1;
      for (int i = 0; i < 7; i++) step();
      total++;
      if (q !== 4'd7) begin bad++; $display("FAIL count7: got %0d want 7", q); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (q !== 4'd0) begin bad++; $display("FAIL midreset_q: got %0d want 0", q); end
      total++;
      if (not_q !== 4'b1111) begin bad++; $display("FAIL midreset_nq: got %b want 1111", not_q); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      total++;
      if (q !== 4'd1) begin bad++; $display("FAIL after_reset: got %0d want 1", q); end
   endtask

   task automatic test_up_wrap();
      logic [3:0] exp_q [3];
      logic       exp_tc [4];
      exp_q  = '{4'd9, 4'd0, 4'd1};
      exp_tc = '{1'b0, 1'b1, 1'b0, 1'b0};
      load = 1'b1; d = 4'd8; en = 1'b0; up = 1'b1;
      step();
      load = 1'b0;
      total++;
      if (q !== 4'd8) begin bad++; $display("FAIL load8: got %0d want 8", q); end
      en = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (tc !== exp_tc[i]) begin bad++; $display("FAIL up_tc%0d: got %b want %b", i, tc, exp_tc[i]); end
         step();
         total++;
         if (q !== exp_q[i]) begin bad++; $display("FAIL up_q%0d: got %0d want %0d", i, q, exp_q[i]); end
      end
      total++;
      if (tc !== exp_tc[3]) begin bad++; $display("FAIL up_tc3: got %b want %b", tc, exp_tc[3]); end
   endtask

   task automatic test_down_wrap();
      logic [3:0] exp_q [3];
      logic       exp_tc [3];
      exp_q  = '{4'd0, 4'd9, 4'd8};
      exp_tc = '{1'b0, 1'b1, 1'b0};
      load = 1'b1; d = 4'd1; en = 1'b0;
      step();
      load = 1'b0;
      total++;
      if (q !== 4'd1) begin bad++; $display("FAIL load1: got %0d want 1", q); end
      en = 1'b1; up = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (tc !== exp_tc[i]) begin bad++; $display("FAIL dn_tc%0d: got %b want %b", i, tc, exp_tc[i]); end
         step();
         total++;
         if (q !== exp_q[i]) begin bad++; $display("FAIL dn_q%0d: got %0d want %0d", i, q, exp_q[i]); end
      end
   endtask

   task automatic test_load_clamp();
      load = 1'b1; d = 4'd9; en = 1'b0; up = 1'b1;
      step();
      total++;
      if (q !== 4'd9) begin bad++; $display("FAIL load9: got %0d want 9", q); end
      // at Q=9 with EN=UP=1 a count would wrap; load must win and mask TC
      en = 1'b1; d = 4'd13; #1;
      total++;
      if (tc !== 1'b0) begin bad++; $display("FAIL load_tc: got %b want 0", tc); end
      step();
      total++;
      if (q !== 4'd9) begin bad++; $display("FAIL clamp13: got %0d want 9", q); end
      d = 4'd5;
      step();
      total++;
      if (q !== 4'd5) begin bad++; $display("FAIL load5: got %0d want 5", q); end
      load = 1'b0; en = 1'b0;
   endtask

   task automatic test_hold();
      en = 1'b0; load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         up = ~up; #1;
         total++;
         if ({dut.j_bits, dut.k_bits} !== 8'h00) begin
            bad++; $display("FAIL hold_jk%0d: got j=%b k=%b want 0000", i, dut.j_bits, dut.k_bits);
         end
         step();
         total++;
         if (q !== 4'd5) begin bad++; $display("FAIL hold_q%0d: got %0d want 5", i, q); end
         total++;
         if (not_q !== 4'b1010) begin bad++; $display("FAIL hold_nq%0d: got %b want 1010", i, not_q); end
      end
   endtask

   task automatic test_cascade();
      c_rst_n = 1'b0;
      #1;
      total++;
      if ({hi_q, lo_q} !== 8'd0) begin bad++; $display("FAIL casc_reset: got %0d want 0", {hi_q, lo_q}); end
      @(negedge clk);
      c_rst_n = 1'b1;
      for (int i = 0; i < 300; i++) step();
      total++;
      if ({hi_q, lo_q} !== 8'd44) begin bad++; $display("FAIL casc300: got %0d want 44", {hi_q, lo_q}); end
      total++;
      if ({hi_nq, lo_nq} !== 8'hD3) begin bad++; $display("FAIL casc_nq: got %h want d3", {hi_nq, lo_nq}); end
   endtask

   initial begin
      c_rst_n = 1'b0;
      test_reset();
      test_reset_mid_count();
      test_up_wrap();
      test_down_wrap();
      test_load_clamp();
      test_hold();
      test_cascade();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
